// File: rtl/cache_ram_burst_bridge_if.sv
// Bundles the cache-side line request port and the RAM-side burst bus of the bridge.
// slave: the bridge itself. master: the cache/RAM environment driving it.
interface cache_ram_burst_bridge_if #(
  parameter int RAM_ADDR_SIZE   = 13,
  parameter int RAM_WORD_SIZE   = 16,
  parameter int CACHE_STR_WIDTH = 64
);
  logic                       line_req;
  logic                       line_rnw;
  logic [RAM_ADDR_SIZE-1:0]   line_addr;
  logic [CACHE_STR_WIDTH-1:0] line_wdata;
  logic [CACHE_STR_WIDTH-1:0] line_rdata;
  logic                       line_busy;
  logic                       line_done;
  logic                       line_err;
  logic [RAM_ADDR_SIZE-1:0]   ram_addr;
  logic [RAM_WORD_SIZE-1:0]   ram_wdata;
  logic                       ram_avalid;
  logic                       ram_rnw;
  logic [RAM_WORD_SIZE-1:0]   ram_rdata;
  logic                       ram_rack;

  modport slave (
    input  line_req, line_rnw, line_addr, line_wdata, ram_rdata, ram_rack,
    output line_rdata, line_busy, line_done, line_err,
           ram_addr, ram_wdata, ram_avalid, ram_rnw
  );

  modport master (
    output line_req, line_rnw, line_addr, line_wdata, ram_rdata, ram_rack,
    input  line_rdata, line_busy, line_done, line_err,
           ram_addr, ram_wdata, ram_avalid, ram_rnw
  );
endinterface

// File: rtl/cache_ram_burst_bridge.sv
// Splits one cache-line fill/writeback into a multi-beat RAM burst and reassembles fills.
// Optional watchdog on RBEAT/WACK enabled by defining RAM_TIMEOUT_EN.
module cache_ram_burst_bridge #(
  parameter int RAM_ADDR_SIZE   = 13,
  parameter int RAM_WORD_SIZE   = 16,
  parameter int CACHE_STR_WIDTH = 64,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                    ram_clk,
  input  logic                    rst,
  cache_ram_burst_bridge_if.slave bus
);

  localparam int BEATS = CACHE_STR_WIDTH / RAM_WORD_SIZE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (TIMEOUT_CYCLES < 1 || BEATS * RAM_WORD_SIZE != CACHE_STR_WIDTH) begin : g_cfg_check
    $error("cache_ram_burst_bridge: bad TIMEOUT_CYCLES or line/word width ratio");
  end

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RBEAT, S_WBEAT, S_WACK, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [RAM_ADDR_SIZE-1:0]   r_addr, w_addr_nxt;
  logic                       r_rnw, w_rnw_nxt;
  logic [CACHE_STR_WIDTH-1:0] r_wline, w_wline_nxt;
  logic [CACHE_STR_WIDTH-1:0] r_buf, w_buf_nxt, w_buf_ins;
  logic [CACHE_STR_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [RAM_WORD_SIZE-1:0]   r_ram_wdata, w_ram_wdata_nxt, w_wbeat;
  logic                       r_busy, w_busy_nxt;
  logic                       r_done, w_done_nxt;
  logic                       r_err, w_err_nxt;
  logic                       r_avalid, w_avalid_nxt;
  logic                       w_accept, w_last, w_timeout;

  assign w_accept = (r_state == S_IDLE) && bus.line_req;
  assign w_last   = (r_cnt == LAST_BEAT);

`ifdef RAM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_wd;
  logic            w_waiting;

  assign w_waiting = (r_state == S_RBEAT) || (r_state == S_WACK);
  // Fires on the TIMEOUT_CYCLES-th consecutive rack-less cycle of a wait state.
  assign w_timeout = w_waiting && !bus.ram_rack && (r_wd == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      r_wd <= '0;
    end else if (w_waiting && !bus.ram_rack && !w_timeout) begin
      r_wd <= r_wd + 1'b1;
    end else begin
      r_wd <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.line_req) w_state_nxt = bus.line_rnw ? S_RADDR : S_WBEAT;
      end
      S_RADDR: w_state_nxt = S_RBEAT;
      S_RBEAT: begin
        if (bus.ram_rack) begin
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end
      end
      S_WBEAT: begin
        w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
        if (w_last) w_state_nxt = S_WACK;
      end
      S_WACK: if (bus.ram_rack || w_timeout) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_buf_ins = r_buf;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (r_cnt == CNT_W'(k)) w_buf_ins[k*RAM_WORD_SIZE +: RAM_WORD_SIZE] = bus.ram_rdata;
    end
  end

  // Beat source comes straight from the port on the accept edge, from the latch afterwards.
  always_comb begin
    w_wbeat = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (w_cnt_nxt == CNT_W'(k)) w_wbeat = w_wline_nxt[k*RAM_WORD_SIZE +: RAM_WORD_SIZE];
    end
  end

  always_comb begin
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_err_nxt       = w_done_nxt && w_timeout;
    w_avalid_nxt    = w_accept;
    w_addr_nxt      = r_addr;
    w_rnw_nxt       = r_rnw;
    w_wline_nxt     = r_wline;
    w_buf_nxt       = r_buf;
    w_rdata_nxt     = r_rdata;
    if (w_accept) begin
      w_addr_nxt  = bus.line_addr;
      w_rnw_nxt   = bus.line_rnw;
      w_wline_nxt = bus.line_wdata;
      w_buf_nxt   = '0;
    end
    if (r_state == S_RBEAT && bus.ram_rack) w_buf_nxt = w_buf_ins;
    if (r_state == S_RBEAT && w_state_nxt == S_DONE) w_rdata_nxt = w_buf_nxt;
    w_ram_wdata_nxt = (w_state_nxt == S_WBEAT) ? w_wbeat : '0;
  end

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_rnw       <= 1'b0;
      r_wline     <= '0;
      r_buf       <= '0;
      r_rdata     <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_avalid    <= 1'b0;
    end else begin
      r_addr      <= w_addr_nxt;
      r_rnw       <= w_rnw_nxt;
      r_wline     <= w_wline_nxt;
      r_buf       <= w_buf_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_avalid    <= w_avalid_nxt;
    end
  end

  assign bus.line_rdata = r_rdata;
  assign bus.line_busy  = r_busy;
  assign bus.line_done  = r_done;
  assign bus.line_err   = r_err;
  assign bus.ram_addr   = r_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.ram_avalid = r_avalid;
  assign bus.ram_rnw    = r_rnw;

endmodule
